// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// FSM state type and the access legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // Unsigned loads have no store counterpart, so 100/101 are illegal for stores.
  function automatic logic access_fault(input logic [2:0] f3,
                                        input logic [1:0] addr_lo,
                                        input logic       is_store);
    logic bad_f3;
    logic misaligned;
    case (f3)
      F3_B, F3_H, F3_W: bad_f3 = 1'b0;
      F3_BU, F3_HU:     bad_f3 = is_store;
      default:          bad_f3 = 1'b1;
    endcase
    misaligned = ((f3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
    return bad_f3 | misaligned;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the bus word
// and sign- or zero-extends it according to funct3.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'b0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'b0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: single-outstanding request/ready data-memory access,
// load extension, and pipeline stall while a transaction is in flight.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exValid,
  input  logic [XLEN-1:0] exALUOutput,
  input  logic [XLEN-1:0] exRs2Data,
  input  logic [2:0]      exFunct3,
  input  logic            exMemRead,
  input  logic            exMemWrite,
  input  logic [4:0]      exRd,
  input  logic            exRegWrite,
  input  logic            exMemtoReg,
  output logic            memReq,
  output logic            memWe,
  output logic [XLEN-1:0] memAddr,
  output logic [XLEN-1:0] memWdata,
  output logic [3:0]      memWstrb,
  input  logic [XLEN-1:0] memRdata,
  input  logic            memReady,
  output logic [XLEN-1:0] wbALUOutput,
  output logic [XLEN-1:0] wbDataOutput,
  output logic [4:0]      wbRd,
  output logic            wbRegWrite,
  output logic            wbMemtoReg,
  output logic            stall,
  output logic            accessFault
);

  lsu_state_e state, state_next;

  logic            mem_op, fault, start;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_wstrb;

  logic [XLEN-1:0] addr_q, wdata_q, lat_alu, lat_rdata, ext_data;
  logic [3:0]      wstrb_q;
  logic            we_q, lat_we, lat_regwrite, lat_memtoreg;
  logic [2:0]      lat_funct3;
  logic [4:0]      lat_rd;

  assign mem_op = exValid & (exMemRead | exMemWrite);
  assign fault  = mem_op & access_fault(exFunct3, exALUOutput[1:0], exMemWrite);
  assign start  = mem_op & ~fault;

  always_comb begin
    st_wdata = exRs2Data;
    st_wstrb = 4'b1111;
    case (exFunct3)
      F3_B: begin
        st_wdata = {4{exRs2Data[7:0]}};
        st_wstrb = 4'b0001 << exALUOutput[1:0];
      end
      F3_H: begin
        st_wdata = {2{exRs2Data[15:0]}};
        st_wstrb = 4'b0011 << exALUOutput[1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (memReady) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      we_q         <= 1'b0;
      lat_alu      <= '0;
      lat_rdata    <= '0;
      lat_funct3   <= '0;
      lat_we       <= 1'b0;
      lat_rd       <= '0;
      lat_regwrite <= 1'b0;
      lat_memtoreg <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        addr_q       <= {exALUOutput[XLEN-1:2], 2'b00};
        wdata_q      <= exMemWrite ? st_wdata : '0;
        wstrb_q      <= exMemWrite ? st_wstrb : '0;
        we_q         <= exMemWrite;
        lat_alu      <= exALUOutput;
        lat_funct3   <= exFunct3;
        lat_we       <= exMemWrite;
        lat_rd       <= exRd;
        lat_regwrite <= exRegWrite;
        lat_memtoreg <= exMemtoReg;
      end
      if ((state == BUSY) && memReady) lat_rdata <= memRdata;
    end
  end

  load_align u_load_align (
    .rdata  (lat_rdata),
    .addr   (lat_alu[1:0]),
    .funct3 (lat_funct3),
    .data   (ext_data)
  );

  assign memWe    = we_q;
  assign memAddr  = addr_q;
  assign memWdata = wdata_q;
  assign memWstrb = wstrb_q;

  // IDLE outputs are gated by rst so stall/accessFault read 0 while reset is held.
  always_comb begin
    memReq       = 1'b0;
    stall        = 1'b0;
    accessFault  = 1'b0;
    wbALUOutput  = exALUOutput;
    wbDataOutput = '0;
    wbRd         = exRd;
    wbRegWrite   = exRegWrite;
    wbMemtoReg   = exMemtoReg;
    unique case (state)
      IDLE: begin
        if (!exValid) begin
          wbALUOutput = '0;
          wbRd        = '0;
          wbRegWrite  = 1'b0;
          wbMemtoReg  = 1'b0;
        end else if (fault) begin
          accessFault = rst;
          wbRegWrite  = 1'b0;
        end else if (start) begin
          stall = rst;
        end
      end
      BUSY: begin
        memReq      = 1'b1;
        stall       = 1'b1;
        wbALUOutput = lat_alu;
        wbRd        = lat_rd;
        wbRegWrite  = lat_regwrite & ~lat_we;
        wbMemtoReg  = lat_memtoreg;
      end
      DONE: begin
        wbALUOutput  = lat_alu;
        wbDataOutput = lat_we ? '0 : ext_data;
        wbRd         = lat_rd;
        wbRegWrite   = lat_regwrite & ~lat_we;
        wbMemtoReg   = lat_memtoreg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu and its load_align sub-module.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        exValid, exMemRead, exMemWrite, exRegWrite, exMemtoReg;
  logic [31:0] exALUOutput, exRs2Data, memRdata;
  logic [2:0]  exFunct3;
  logic [4:0]  exRd;
  logic        memReq, memWe, memReady, wbRegWrite, wbMemtoReg, stall, accessFault;
  logic [31:0] memAddr, memWdata, wbALUOutput, wbDataOutput;
  logic [3:0]  memWstrb;
  logic [4:0]  wbRd;

  logic [31:0] la_rdata, la_data;
  logic [1:0]  la_addr;
  logic [2:0]  la_funct3;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .exValid(exValid), .exALUOutput(exALUOutput),
    .exRs2Data(exRs2Data), .exFunct3(exFunct3), .exMemRead(exMemRead),
    .exMemWrite(exMemWrite), .exRd(exRd), .exRegWrite(exRegWrite),
    .exMemtoReg(exMemtoReg), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
    .memWdata(memWdata), .memWstrb(memWstrb), .memRdata(memRdata),
    .memReady(memReady), .wbALUOutput(wbALUOutput), .wbDataOutput(wbDataOutput),
    .wbRd(wbRd), .wbRegWrite(wbRegWrite), .wbMemtoReg(wbMemtoReg),
    .stall(stall), .accessFault(accessFault)
  );

  load_align u_la (.rdata(la_rdata), .addr(la_addr), .funct3(la_funct3), .data(la_data));

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic [31:0] e_data;
    logic        e_rw;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        rw;
    logic [31:0] alu;
    logic [4:0]  rd;
  } sb_t;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
  } fvec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  addr;
    logic [2:0]  f3;
    logic [31:0] exp;
  } lavec_t;

  vec_t   vecs[$];
  fvec_t  fvecs[$];
  lavec_t lavecs[$];
  sb_t    sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic idle_inputs();
    exValid = 1'b0; exMemRead = 1'b0; exMemWrite = 1'b0; exRegWrite = 1'b0;
    exMemtoReg = 1'b0; exALUOutput = '0; exRs2Data = '0; exFunct3 = '0; exRd = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the DONE cycle.
  task automatic do_mem(input vec_t v, input int idx);
    sb_t e, got;
    int  stall_cnt;
    stall_cnt   = 0;
    exValid     = 1'b1;
    exMemRead   = ~v.st;
    exMemWrite  = v.st;
    exFunct3    = v.f3;
    exALUOutput = v.addr;
    exRs2Data   = v.wdata;
    exRd        = 5'(idx + 1);
    exRegWrite  = 1'b1;
    exMemtoReg  = ~v.st;
    e = '{data: v.e_data, rw: v.e_rw, alu: v.addr, rd: 5'(idx + 1)};
    sb.push_back(e);
    @(negedge clk);
    if (stall) stall_cnt++;
    check($sformatf("v%0d req_idle", idx), {31'b0, memReq}, 32'd0);
    @(posedge clk); #1;
    for (int i = 1; i <= v.lat; i++) begin
      memReady = (i == v.lat);
      memRdata = (i == v.lat) ? v.rdata : $urandom;
      @(negedge clk);
      if (stall) stall_cnt++;
      check($sformatf("v%0d req_busy%0d", idx, i), {31'b0, memReq}, 32'd1);
      check($sformatf("v%0d addr%0d", idx, i), memAddr, v.e_addr);
      check($sformatf("v%0d we%0d", idx, i), {31'b0, memWe}, {31'b0, v.st});
      if (v.st) begin
        check($sformatf("v%0d wdata%0d", idx, i), memWdata, v.e_wdata);
        check($sformatf("v%0d wstrb%0d", idx, i), {28'b0, memWstrb}, {28'b0, v.e_wstrb});
      end
      @(posedge clk); #1;
    end
    memReady = 1'b0;
    memRdata = $urandom;
    @(negedge clk);
    check($sformatf("v%0d req_done", idx), {31'b0, memReq}, 32'd0);
    check($sformatf("v%0d stall_done", idx), {31'b0, stall}, 32'd0);
    check($sformatf("v%0d stall_cycles", idx), 32'(stall_cnt), 32'(v.lat + 1));
    if (sb.size() == 0) begin
      check($sformatf("v%0d sb_empty", idx), 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check($sformatf("v%0d wbdata", idx), wbDataOutput, got.data);
      check($sformatf("v%0d wbregwrite", idx), {31'b0, wbRegWrite}, {31'b0, got.rw});
      check($sformatf("v%0d wbalu", idx), wbALUOutput, got.alu);
      check($sformatf("v%0d wbrd", idx), {27'b0, wbRd}, {27'b0, got.rd});
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //            st  f3    addr          wdata         rdata         lat e_addr        e_wdata       strb     e_data        rw
    vecs.push_back('{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 3, 32'h0000_0100, 32'h0,        4'b0000, 32'hDEAD_BEEF, 1'b1});
    vecs.push_back('{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 1, 32'h0000_0100, 32'h0,        4'b0000, 32'hFFFF_FF80, 1'b1});
    vecs.push_back('{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 2, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_0080, 1'b1});
    vecs.push_back('{1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        1, 32'h0000_0200, 32'hABCD_ABCD, 4'b1100, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 3'b000, 32'h0000_0301, 32'hCAFE_00A5, 32'h0,        2, 32'h0000_0300, 32'hA5A5_A5A5, 4'b0010, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 3'b010, 32'h0000_0404, 32'h1122_3344, 32'h0,        2, 32'h0000_0404, 32'h1122_3344, 4'b1111, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 1, 32'h0000_0100, 32'h0,        4'b0000, 32'hFFFF_8001, 1'b1});
    vecs.push_back('{1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 1, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_8001, 1'b1});
    vecs.push_back('{1'b0, 3'b001, 32'h0000_0100, 32'h0,        32'h8001_7FFF, 2, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_7FFF, 1'b1});
    vecs.push_back('{1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h1234_5678, 1, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_0056, 1'b1});
    vecs.push_back('{1'b0, 3'b100, 32'h0000_0100, 32'h0,        32'h0000_00FE, 4, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_00FE, 1'b1});

    fvecs.push_back('{1'b0, 3'b010, 32'h0000_0101});
    fvecs.push_back('{1'b0, 3'b001, 32'h0000_0103});
    fvecs.push_back('{1'b1, 3'b001, 32'h0000_0201});
    fvecs.push_back('{1'b1, 3'b010, 32'h0000_0202});
    fvecs.push_back('{1'b1, 3'b100, 32'h0000_0000});
    fvecs.push_back('{1'b0, 3'b011, 32'h0000_0000});
    fvecs.push_back('{1'b0, 3'b110, 32'h0000_0000});

    lavecs.push_back('{32'h80FF_FFFF, 2'd3, 3'b000, 32'hFFFF_FF80});
    lavecs.push_back('{32'h80FF_FFFF, 2'd3, 3'b100, 32'h0000_0080});
    lavecs.push_back('{32'h8001_7FFF, 2'd2, 3'b001, 32'hFFFF_8001});
    lavecs.push_back('{32'h8001_7FFF, 2'd0, 3'b101, 32'h0000_7FFF});
    lavecs.push_back('{32'hCAFE_BABE, 2'd0, 3'b010, 32'hCAFE_BABE});
    lavecs.push_back('{32'h1234_5678, 2'd2, 3'b000, 32'h0000_0034});
    lavecs.push_back('{32'h1234_5678, 2'd1, 3'b100, 32'h0000_0056});

    foreach (lavecs[i]) begin
      la_rdata = lavecs[i].rdata; la_addr = lavecs[i].addr; la_funct3 = lavecs[i].f3;
      #1;
      check($sformatf("load_align%0d", i), la_data, lavecs[i].exp);
    end

    rst = 1'b0; memReady = 1'b0; memRdata = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst memReq", {31'b0, memReq}, 32'd0);
    check("rst memWe", {31'b0, memWe}, 32'd0);
    check("rst memAddr", memAddr, 32'd0);
    check("rst memWdata", memWdata, 32'd0);
    check("rst memWstrb", {28'b0, memWstrb}, 32'd0);
    check("rst stall", {31'b0, stall}, 32'd0);
    check("rst accessFault", {31'b0, accessFault}, 32'd0);
    check("rst wbRegWrite", {31'b0, wbRegWrite}, 32'd0);
    check("rst wbDataOutput", wbDataOutput, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    exValid = 1'b1; exALUOutput = 32'h0000_55AA; exRd = 5'd7; exRegWrite = 1'b1;
    #1;
    check("alu wbALUOutput", wbALUOutput, 32'h0000_55AA);
    check("alu wbRd", {27'b0, wbRd}, 32'd7);
    check("alu wbRegWrite", {31'b0, wbRegWrite}, 32'd1);
    check("alu wbDataOutput", wbDataOutput, 32'd0);
    check("alu stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();

    foreach (vecs[i]) do_mem(vecs[i], i);

    foreach (fvecs[i]) begin
      exValid = 1'b1; exMemRead = ~fvecs[i].st; exMemWrite = fvecs[i].st;
      exFunct3 = fvecs[i].f3; exALUOutput = fvecs[i].addr; exRegWrite = 1'b1; exRd = 5'd9;
      @(negedge clk);
      check($sformatf("f%0d accessFault", i), {31'b0, accessFault}, 32'd1);
      check($sformatf("f%0d wbRegWrite", i), {31'b0, wbRegWrite}, 32'd0);
      check($sformatf("f%0d stall", i), {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check($sformatf("f%0d memReq", i), {31'b0, memReq}, 32'd0);
      check($sformatf("f%0d fault_pulse", i), {31'b0, accessFault}, 32'd0);
      @(posedge clk); #1;
    end

    exValid = 1'b1; exMemRead = 1'b1; exFunct3 = 3'b010; exALUOutput = 32'h0000_0500;
    exRegWrite = 1'b1; exRd = 5'd4;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid memReq_busy", {31'b0, memReq}, 32'd1);
    #1;
    rst = 1'b0;
    idle_inputs();
    exValid = 1'b1; exALUOutput = 32'h0000_0033; exRd = 5'd3; exRegWrite = 1'b1;
    #1;
    check("rstmid memReq_now", {31'b0, memReq}, 32'd0);
    check("rstmid stall_now", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    memReady = 1'b1; memRdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check("rstmid add_stall", {31'b0, stall}, 32'd0);
    check("rstmid add_memReq", {31'b0, memReq}, 32'd0);
    check("rstmid add_alu", wbALUOutput, 32'h0000_0033);
    check("rstmid add_rw", {31'b0, wbRegWrite}, 32'd1);
    @(posedge clk); #1;
    memReady = 1'b0;
    @(negedge clk);
    check("rstmid ready_ignored", {31'b0, memReq}, 32'd0);
    check("rstmid ready_stall", {31'b0, stall}, 32'd0);
    check("sb drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
